sync_fifo_prog: RTL and testbench

Parametrised single-clock FIFO that replaces the team's basic synchronous FIFO in the camera/frame-buffer datapaths. Adds:

- a true full flag at DEPTH entries;
- programmable almost-full and almost-empty thresholds;
- a synchronous flush;
- a selectable first-word-fall-through (FWFT) read mode;
- a registered read path with an explicit data-valid strobe.

It sits between the MIPI pixel unpacker and the DDR/HDMI line buffers, wherever a rate-decoupling queue is needed inside one clock domain.

---
 rtl/fifo_pkg.sv | 18 +
 rtl/sdp_ram.sv | 26 ++
 rtl/sync_fifo_prog.sv | 153 +++++++++++++++
 tb/tb_sync_fifo_prog.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared constants for sync_fifo_prog: read-mode selectors, prefetch FSM encoding
// and the depth helper used to size parameters.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  typedef enum logic [1:0] {
    PF_EMPTY = 2'd0,
    PF_FETCH = 2'd1,
    PF_HOLD  = 2'd2
  } pf_state_e;

  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (1-cycle latency).
// The array has no reset so it maps onto block RAM.
module sdp_ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with full/almost flags, flush, error pulses and an optional
// first-word-fall-through output stage in front of a registered-read RAM.
module sync_fifo_prog
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int FWFT       = FWFT_OFF,
  parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 4,
  parameter int AE_LEVEL   = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  clear,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   level,
  output logic                  overflow_err,
  output logic                  underflow_err
);

  localparam int            LW      = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(fifo_depth(ADDR_WIDTH));
  localparam logic [LW-1:0] AF_L    = LW'(AF_LEVEL);
  localparam logic [LW-1:0] AE_L    = LW'(AE_LEVEL);

  logic [LW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, level_q, level_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  vld_q, vld_d, shown_q, shown_d;
  pf_state_e             pf_q, pf_d;
  logic                  byp_q, byp_d;
  logic [DATA_WIDTH-1:0] out_q, out_d;
  logic [DATA_WIDTH-1:0] ram_rdata;
  logic                  flush, ram_has, wr_acc, rd_acc, ram_re, head_vld, byp_head;

  assign flush    = clear | ~nrst;
  assign ram_has  = (wr_ptr_q != rd_ptr_q);
  // In FETCH after a pop, the next head already sits in the RAM read register.
  assign byp_head = (pf_q == PF_FETCH) & byp_q;
  assign head_vld = (FWFT == FWFT_ON) ? ((pf_q == PF_HOLD) | byp_head) : vld_q;

  assign full   = (level_q == DEPTH_L);
  assign empty  = (FWFT == FWFT_ON) ? ~head_vld : (level_q == '0);
  assign wr_acc = we & ~full & ~flush;
  assign rd_acc = re & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q + LW'(wr_acc);
    level_d  = level_q;
    if (wr_acc & ~rd_acc) level_d = level_q + LW'(1);
    if (rd_acc & ~wr_acc) level_d = level_q - LW'(1);
    ovf_d    = we & full;
    unf_d    = re & empty;
    vld_d    = 1'b0;
    shown_d  = shown_q;
    pf_d     = pf_q;
    byp_d    = byp_q;
    out_d    = out_q;
    ram_re   = 1'b0;
    if (FWFT == FWFT_ON) begin
      case (pf_q)
        PF_EMPTY: begin
          if (ram_has & ~flush) begin
            ram_re = 1'b1;
            pf_d   = PF_FETCH;
            byp_d  = 1'b0;
          end
        end
        PF_FETCH: begin
          if (rd_acc) begin
            ram_re = ram_has;
            pf_d   = ram_has ? PF_FETCH : PF_EMPTY;
            byp_d  = ram_has;
          end else begin
            out_d = ram_rdata;
            pf_d  = PF_HOLD;
            byp_d = 1'b0;
          end
        end
        PF_HOLD: begin
          if (rd_acc) begin
            ram_re = ram_has;
            pf_d   = ram_has ? PF_FETCH : PF_EMPTY;
            byp_d  = ram_has;
          end
        end
        default: pf_d = PF_EMPTY;
      endcase
    end else begin
      ram_re = rd_acc;
      vld_d  = rd_acc;
      if (rd_acc) shown_d = 1'b1;
    end
    rd_ptr_d = rd_ptr_q + LW'(ram_re);
  end

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      vld_q    <= 1'b0;
      shown_q  <= 1'b0;
      pf_q     <= PF_EMPTY;
      byp_q    <= 1'b0;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      vld_q    <= vld_d;
      shown_q  <= shown_d;
      pf_q     <= pf_d;
      byp_q    <= byp_d;
      out_q    <= out_d;
    end
  end

  sdp_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata (data_in),
    .re    (ram_re),
    .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata (ram_rdata)
  );

  // Standard mode masks the unreset RAM register until the first real read.
  assign data_out      = (FWFT == FWFT_ON) ? (byp_head ? ram_rdata : out_q)
                                           : (shown_q ? ram_rdata : '0);
  assign valid         = head_vld;
  assign almost_full   = (level_q >= AF_L);
  assign almost_empty  = (level_q <= AE_L);
  assign level         = level_q;
  assign overflow_err  = ovf_q;
  assign underflow_err = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a standard-mode and an FWFT instance (16 deep) driven
// with directed and random traffic and compared against queue-based models.
module tb_sync_fifo_prog;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       nrst;
  logic       s_clear, s_we, s_re, s_valid, s_empty, s_full, s_af, s_ae, s_ovf, s_unf;
  logic [7:0] s_din, s_dout;
  logic [4:0] s_level;
  logic       f_clear, f_we, f_re, f_valid, f_empty, f_full, f_af, f_ae, f_ovf, f_unf;
  logic [7:0] f_din, f_dout;
  logic [4:0] f_level;

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(3)) u_std (
    .clk(clk), .nrst(nrst), .clear(s_clear), .we(s_we), .data_in(s_din), .re(s_re),
    .data_out(s_dout), .valid(s_valid), .empty(s_empty), .full(s_full),
    .almost_full(s_af), .almost_empty(s_ae), .level(s_level),
    .overflow_err(s_ovf), .underflow_err(s_unf));

  sync_fifo_prog #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(3)) u_fw (
    .clk(clk), .nrst(nrst), .clear(f_clear), .we(f_we), .data_in(f_din), .re(f_re),
    .data_out(f_dout), .valid(f_valid), .empty(f_empty), .full(f_full),
    .almost_full(f_af), .almost_empty(f_ae), .level(f_level),
    .overflow_err(f_ovf), .underflow_err(f_unf));

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sq[$];
  logic [7:0] fq[$];
  logic [7:0] exp_dout;
  bit         exp_valid, exp_ovf, exp_unf;
  bit         f_popped;
  logic [7:0] f_act, f_exp;
  logic [11:0] s_flags;

  assign s_flags = {s_level, s_full, s_empty, s_af, s_ae, s_valid, s_ovf, s_unf};

  // Expected standard-mode flag vector from the model occupancy.
  function automatic logic [11:0] std_exp();
    int n;
    n = sq.size();
    return {5'(n), n == 16, n == 0, n >= 12, n <= 3, exp_valid, exp_ovf, exp_unf};
  endfunction

  task automatic std_step(input bit w, input logic [7:0] d, input bit r);
    bit full_m, empty_m;
    full_m  = (sq.size() == 16);
    empty_m = (sq.size() == 0);
    s_we = w; s_din = d; s_re = r;
    exp_ovf   = w && full_m;
    exp_unf   = r && empty_m;
    exp_valid = r && !empty_m;
    if (exp_valid) exp_dout = sq.pop_front();
    if (w && !full_m) sq.push_back(d);
    @(posedge clk); #1;
    s_we = 1'b0; s_re = 1'b0;
  endtask

  task automatic fw_step(input bit w, input logic [7:0] d, input bit r);
    bit full_m;
    full_m = (fq.size() == 16);
    f_we = w; f_din = d; f_re = r;
    f_popped = r && (f_valid === 1'b1);
    f_act = f_dout;
    if (f_popped) f_exp = (fq.size() != 0) ? fq.pop_front() : 8'hxx;
    if (w && !full_m) fq.push_back(d);
    @(posedge clk); #1;
    f_we = 1'b0; f_re = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    s_clear = 0; s_we = 0; s_re = 0; s_din = '0;
    f_clear = 0; f_we = 0; f_re = 0; f_din = '0;
    repeat (2) @(posedge clk);
    #1;
    sq.delete(); fq.delete();
    exp_dout = '0; exp_valid = 0; exp_ovf = 0; exp_unf = 0;
    checks++;
    if (s_flags !== std_exp()) begin
      errors++; $display("FAIL reset_std_flags: got %b want %b", s_flags, std_exp());
    end
    checks++;
    if (s_dout !== 8'h00) begin
      errors++; $display("FAIL reset_std_dout: got %h want 00", s_dout);
    end
    checks++;
    if ({f_level, f_empty, f_full, f_af, f_ae, f_valid, f_dout} !== {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_fwft: got lvl=%0d e=%b f=%b af=%b ae=%b v=%b d=%h want 0 1 0 0 1 0 00",
                         f_level, f_empty, f_full, f_af, f_ae, f_valid, f_dout);
    end
    nrst = 1'b1;
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 16; i++) begin
      std_step(1'b1, 8'(i), 1'b0);
      checks++;
      if (s_flags !== std_exp()) begin
        errors++; $display("FAIL fill_flags i=%0d: got %b want %b", i, s_flags, std_exp());
      end
    end
    std_step(1'b1, 8'hEE, 1'b0);
    checks++;
    if (s_flags !== std_exp()) begin
      errors++; $display("FAIL overflow_pulse: got %b want %b", s_flags, std_exp());
    end
    std_step(1'b1, 8'hDD, 1'b1);
    checks++;
    if (s_flags !== std_exp() || s_dout !== exp_dout) begin
      errors++; $display("FAIL full_we_re: got %b/%h want %b/%h", s_flags, s_dout, std_exp(), exp_dout);
    end
    while (sq.size() != 0) begin
      std_step(1'b0, 8'h00, 1'b1);
      checks++;
      if (s_flags !== std_exp() || s_dout !== exp_dout) begin
        errors++; $display("FAIL drain: got %b/%h want %b/%h", s_flags, s_dout, std_exp(), exp_dout);
      end
    end
    std_step(1'b0, 8'h00, 1'b0);
    checks++;
    if (s_flags !== std_exp() || s_dout !== exp_dout) begin
      errors++; $display("FAIL drain_idle_hold: got %b/%h want %b/%h", s_flags, s_dout, std_exp(), exp_dout);
    end
  endtask

  task automatic test_underflow();
    std_step(1'b0, 8'h00, 1'b1);
    checks++;
    if (s_flags !== std_exp()) begin
      errors++; $display("FAIL underflow_pulse: got %b want %b", s_flags, std_exp());
    end
    std_step(1'b0, 8'h00, 1'b0);
    checks++;
    if (s_flags !== std_exp()) begin
      errors++; $display("FAIL underflow_clear: got %b want %b", s_flags, std_exp());
    end
    std_step(1'b1, 8'h55, 1'b1);
    checks++;
    if (s_flags !== std_exp()) begin
      errors++; $display("FAIL empty_we_re: got %b want %b", s_flags, std_exp());
    end
    std_step(1'b0, 8'h00, 1'b1);
    checks++;
    if (s_flags !== std_exp() || s_dout !== exp_dout) begin
      errors++; $display("FAIL empty_we_re_read: got %b/%h want %b/%h", s_flags, s_dout, std_exp(), exp_dout);
    end
  endtask

  task automatic test_back_to_back();
    while (sq.size() < 8) std_step(1'b1, 8'($urandom), 1'b0);
    for (int c = 0; c < 100; c++) begin
      std_step(1'b1, 8'($urandom), 1'b1);
      checks++;
      if (s_flags !== std_exp() || s_dout !== exp_dout) begin
        errors++; $display("FAIL simul c=%0d: got %b/%h want %b/%h", c, s_flags, s_dout, std_exp(), exp_dout);
      end
    end
  endtask

  task automatic test_thresholds();
    while (sq.size() != 0) std_step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 13; i++) begin
      std_step(1'b1, 8'($urandom), 1'b0);
      checks++;
      if (s_flags !== std_exp()) begin
        errors++; $display("FAIL thresh_up n=%0d: got %b want %b", i + 1, s_flags, std_exp());
      end
    end
    for (int c = 0; c < 300; c++) begin
      bit w, r;
      w = ($urandom_range(0, 99) < ((c < 150) ? 70 : 30));
      r = ($urandom_range(0, 99) < ((c < 150) ? 30 : 70));
      std_step(w, 8'($urandom), r);
      checks++;
      if (s_flags !== std_exp() || s_dout !== exp_dout) begin
        errors++; $display("FAIL std_random c=%0d: got %b/%h want %b/%h", c, s_flags, s_dout, std_exp(), exp_dout);
      end
    end
  endtask

  task automatic test_clear();
    while (sq.size() < 9) std_step(1'b1, 8'($urandom), 1'b0);
    while (sq.size() > 9) std_step(1'b0, 8'h00, 1'b1);
    s_clear = 1'b1; s_we = 1'b1; s_din = 8'h77;
    @(posedge clk); #1;
    s_clear = 1'b0; s_we = 1'b0;
    sq.delete(); exp_dout = '0; exp_valid = 0; exp_ovf = 0; exp_unf = 0;
    checks++;
    if (s_flags !== std_exp() || s_dout !== 8'h00) begin
      errors++; $display("FAIL clear_std: got %b/%h want %b/00", s_flags, s_dout, std_exp());
    end
    std_step(1'b1, 8'h3C, 1'b0);
    std_step(1'b0, 8'h00, 1'b1);
    checks++;
    if (s_flags !== std_exp() || s_dout !== 8'h3C) begin
      errors++; $display("FAIL clear_std_reuse: got %b/%h want %b/3c", s_flags, s_dout, std_exp());
    end
  endtask

  task automatic test_fwft_single();
    fw_step(1'b1, 8'hA5, 1'b0);
    checks++;
    if ({f_empty, f_level} !== {1'b1, 5'd1}) begin
      errors++; $display("FAIL fwft_t0: got e=%b lvl=%0d want e=1 lvl=1", f_empty, f_level);
    end
    fw_step(1'b0, 8'h00, 1'b0);
    checks++;
    if (f_empty !== 1'b1) begin
      errors++; $display("FAIL fwft_t1: got e=%b want 1", f_empty);
    end
    fw_step(1'b0, 8'h00, 1'b0);
    checks++;
    if ({f_empty, f_valid, f_dout} !== {1'b0, 1'b1, 8'hA5}) begin
      errors++; $display("FAIL fwft_t2: got e=%b v=%b d=%h want 0 1 a5", f_empty, f_valid, f_dout);
    end
    fw_step(1'b0, 8'h00, 1'b1);
    checks++;
    if (!f_popped || f_act !== f_exp || {f_empty, f_level} !== {1'b1, 5'd0}) begin
      errors++; $display("FAIL fwft_pop: got pop=%b d=%h e=%b lvl=%0d want 1 %h 1 0",
                         f_popped, f_act, f_empty, f_level, f_exp);
    end
  endtask

  task automatic test_fwft_stream();
    int  popped_n, gaps;
    bit  started;
    popped_n = 0; gaps = 0; started = 0;
    for (int c = 0; c < 80 && popped_n < 40; c++) begin
      fw_step(c < 40, 8'($urandom), 1'b1);
      if (f_popped) begin
        popped_n++;
        checks++;
        if (f_act !== f_exp) begin
          errors++; $display("FAIL stream_data n=%0d: got %h want %h", popped_n, f_act, f_exp);
        end
      end
      checks++;
      if (f_level !== 5'(fq.size())) begin
        errors++; $display("FAIL stream_level c=%0d: got %0d want %0d", c, f_level, fq.size());
      end
      if (f_valid === 1'b1) started = 1;
      else if (started && c < 40) gaps++;
    end
    checks++;
    if (popped_n != 40) begin
      errors++; $display("FAIL stream_count: got %0d want 40", popped_n);
    end
    checks++;
    if (gaps != 0) begin
      errors++; $display("FAIL stream_gaps: got %0d want 0", gaps);
    end
  endtask

  task automatic test_fwft_random();
    for (int c = 0; c < 300; c++) begin
      bit w, r;
      w = ($urandom_range(0, 99) < ((c < 150) ? 70 : 35));
      r = ($urandom_range(0, 99) < ((c < 150) ? 35 : 70));
      fw_step(w, 8'($urandom), r);
      if (f_popped) begin
        checks++;
        if (f_act !== f_exp) begin
          errors++; $display("FAIL fwft_rand_data c=%0d: got %h want %h", c, f_act, f_exp);
        end
      end
      checks++;
      if ({f_level, f_full, f_af, f_ae} !== {5'(fq.size()), fq.size() == 16, fq.size() >= 12, fq.size() <= 3}) begin
        errors++; $display("FAIL fwft_rand_flags c=%0d: got lvl=%0d f=%b af=%b ae=%b want lvl=%0d",
                           c, f_level, f_full, f_af, f_ae, fq.size());
      end
    end
  endtask

  task automatic test_fwft_clear();
    for (int i = 0; i < 3; i++) fw_step(1'b1, 8'($urandom), 1'b0);
    f_clear = 1'b1; f_we = 1'b1; f_din = 8'h77;
    @(posedge clk); #1;
    f_clear = 1'b0; f_we = 1'b0;
    fq.delete();
    checks++;
    if ({f_level, f_empty, f_valid, f_dout, f_ovf, f_unf} !== {5'd0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      errors++; $display("FAIL clear_fwft: got lvl=%0d e=%b v=%b d=%h want 0 1 0 00", f_level, f_empty, f_valid, f_dout);
    end
    fw_step(1'b1, 8'h3C, 1'b0);
    fw_step(1'b0, 8'h00, 1'b0);
    fw_step(1'b0, 8'h00, 1'b0);
    checks++;
    if ({f_valid, f_dout, f_level} !== {1'b1, 8'h3C, 5'd1}) begin
      errors++; $display("FAIL clear_fwft_reuse: got v=%b d=%h lvl=%0d want 1 3c 1", f_valid, f_dout, f_level);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_underflow();
    test_back_to_back();
    test_thresholds();
    test_clear();
    test_fwft_single();
    test_fwft_stream();
    test_fwft_random();
    test_fwft_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
